// File: rtl/sseg_scan_driver.sv
// -----------------------------------------------------------------------------
// sseg_scan_driver
//   Multiplexed seven-segment driver for DIGITS common-anode digits.
//   - Prescaler sets the digit slot length (PRESCALE clk cycles per digit).
//   - Double-buffered display value: load writes a shadow register, and the
//     shadow reaches the display register only on a frame boundary, so a frame
//     never shows a mix of old and new digits.
//   - Hex decode (0-9, A b C d E F), per-digit decimal points, PWM dimming on
//     the anode enables.
//   - All pin outputs are registered (one cycle behind the scan index).
//
//   Optional feature macro: SSEG_BLANK_LEADING_ZERO_EN
//     When defined, digit k (k >= 1) is blanked while it and every higher
//     digit of the display register are zero. Digit 0 is never blanked, the
//     decimal point and anode scan are unaffected.
// -----------------------------------------------------------------------------
module sseg_scan_driver #(
    parameter int DIGITS   = 4,       // 1..8
    parameter int PRESCALE = 100000,  // clk cycles per digit slot, >= 2
    parameter int PWM_BITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    input  logic [PWM_BITS-1:0]   bright,
    output logic [DIGITS-1:0]     sseg_a_o,
    output logic [6:0]            sseg_c_o,
    output logic                  dp_o,
    output logic                  frame_o
);

    localparam int PRESC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(DIGITS - 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [PRESC_W-1:0]      presc;
    logic [IDX_W-1:0]        idx;
    logic [PWM_BITS-1:0]     pwm_cnt;

    // Nibble k of each register drives digit k (digit 0 is rightmost).
    logic [DIGITS-1:0][3:0]  shadow_bcd;
    logic [DIGITS-1:0]       shadow_dp;
    logic [DIGITS-1:0][3:0]  disp_bcd;
    logic [DIGITS-1:0]       disp_dp;

    // -------------------------------------------------------------------------
    // Combinational helpers
    // -------------------------------------------------------------------------
    logic                    tick;
    logic                    frame_tick;
    logic                    pwm_on;
    logic [DIGITS-1:0]       anode_next;
    logic [6:0]              seg_pat;
    logic [6:0]              seg_next;

    // Hex nibble to active-low cathode pattern, bit 6 = a ... bit 0 = g.
    function automatic logic [6:0] decode_hex(input logic [3:0] nib);
        case (nib)
            4'h0:    return 7'b0000001;
            4'h1:    return 7'b1001111;
            4'h2:    return 7'b0010010;
            4'h3:    return 7'b0000110;
            4'h4:    return 7'b1001100;
            4'h5:    return 7'b0100100;
            4'h6:    return 7'b0100000;
            4'h7:    return 7'b0001111;
            4'h8:    return 7'b0000000;
            4'h9:    return 7'b0000100;
            4'hA:    return 7'b0001000;
            4'hB:    return 7'b1100000;
            4'hC:    return 7'b0110001;
            4'hD:    return 7'b1000010;
            4'hE:    return 7'b0110000;
            default: return 7'b0111000;  // F
        endcase
    endfunction

    assign tick       = (presc == PRESC_LAST);
    assign frame_tick = tick && (idx == IDX_LAST);

    // PWM gate: all-ones brightness means always on (the counter can never be
    // strictly below all-ones on every cycle, so it needs its own term).
    assign pwm_on = (bright == {PWM_BITS{1'b1}}) || (pwm_cnt < bright);

`ifdef SSEG_BLANK_LEADING_ZERO_EN
    logic [DIGITS-1:0] blank_mask;
    logic              upper_zero;

    // Walk from the most significant digit down: a digit is blanked while it
    // and everything above it is zero. Digit 0 stays unblanked.
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch so
        // no path leaves it unassigned, which would infer a latch.
        blank_mask = '0;
        upper_zero = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            upper_zero                = upper_zero && (disp_bcd[IDX_W'(k)] == 4'h0);
            blank_mask[IDX_W'(k)]     = upper_zero;
        end
    end
`endif

    // Next values for the registered pins, derived from the current scan slot.
    always_comb begin
        anode_next = '1;
        if (pwm_on) begin
            anode_next = ~(DIGITS'(1) << idx);
        end
        seg_pat = decode_hex(disp_bcd[idx]);
`ifdef SSEG_BLANK_LEADING_ZERO_EN
        seg_next = blank_mask[idx] ? SEG_BLANK : seg_pat;
`else
        seg_next = seg_pat;
`endif
    end

    // -------------------------------------------------------------------------
    // Scan timebase: prescaler, digit index and free-running PWM counter.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every register
        // samples pre-edge values, independent of block ordering.
        if (!rst_n) begin
            presc   <= '0;
            idx     <= '0;
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (tick) begin
                presc <= '0;
                idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Double buffer: load writes the shadow, frame boundary publishes it; a
    // load on the boundary cycle bypasses the shadow so the newest value wins.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: these value registers are reset on purpose: a reset must blank
        // any pending load and restart from a known all-zero display.
        if (!rst_n) begin
            shadow_bcd <= '0;
            shadow_dp  <= '0;
            disp_bcd   <= '0;
            disp_dp    <= '0;
        end else begin
            if (load) begin
                shadow_bcd <= bcd_in;
                shadow_dp  <= dp_in;
            end
            if (frame_tick) begin
                disp_bcd <= load ? bcd_in : shadow_bcd;
                disp_dp  <= load ? dp_in  : shadow_dp;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registered pin outputs; frame_o lines up with the display register update.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sseg_a_o <= '1;
            sseg_c_o <= SEG_BLANK;
            dp_o     <= 1'b1;
            frame_o  <= 1'b0;
        end else begin
            sseg_a_o <= anode_next;
            sseg_c_o <= seg_next;
            dp_o     <= ~disp_dp[idx];
            frame_o  <= frame_tick;
        end
    end

endmodule

// File: tb/tb_sseg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_sseg_scan_driver
//   DIGITS=4, PRESCALE=4, PWM_BITS=4. A reference model derives the expected
//   pins from the number of clock edges since reset release (slot, digit and
//   PWM phase are plain arithmetic on that count) plus a shadow/display pair
//   updated by the load/boundary rules. A negedge process compares every
//   cycle; directed literal checks pin the model to hand-computed values.
//   Build with +define+SSEG_BLANK_LEADING_ZERO_EN to check the blanking build.
// -----------------------------------------------------------------------------
module tb_sseg_scan_driver;

    localparam int D  = 4;
    localparam int P  = 4;
    localparam int PB = 4;
    localparam int PWM_MOD = 1 << PB;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [15:0]   bcd_in;
    logic [3:0]    dp_in;
    logic          load;
    logic [3:0]    bright;
    logic [3:0]    sseg_a_o;
    logic [6:0]    sseg_c_o;
    logic          dp_o;
    logic          frame_o;

    int n_cmp  = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    sseg_scan_driver #(.DIGITS(D), .PRESCALE(P), .PWM_BITS(PB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bcd_in   (bcd_in),
        .dp_in    (dp_in),
        .load     (load),
        .bright   (bright),
        .sseg_a_o (sseg_a_o),
        .sseg_c_o (sseg_c_o),
        .dp_o     (dp_o),
        .frame_o  (frame_o)
    );

    always #5 clk = ~clk;

    // Cathode patterns straight from the character table, index = nibble.
    logic [6:0] seg_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    // ---------------------------------------------------------------- model
    int unsigned m_k;            // edges since reset release
    logic [15:0] m_sh_bcd, m_disp_bcd;
    logic [3:0]  m_sh_dp,  m_disp_dp;
    logic [3:0]  exp_a;
    logic [6:0]  exp_c;
    logic        exp_dp, exp_frame;
    int          m_slot, m_idx, m_pwm;
    bit          m_boundary, m_on, m_blank;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_k = 0;
            m_sh_bcd = '0; m_disp_bcd = '0; m_sh_dp = '0; m_disp_dp = '0;
            exp_a = 4'hF; exp_c = 7'h7F; exp_dp = 1'b1; exp_frame = 1'b0;
        end else begin
            m_slot     = int'(m_k / P);
            m_idx      = m_slot % D;
            m_pwm      = int'(m_k % PWM_MOD);
            m_boundary = ((m_k % (P * D)) == (P * D - 1));
            m_on       = (bright == 4'hF) || (m_pwm < int'(bright));
            exp_a      = m_on ? ~(4'b0001 << m_idx) : 4'hF;
            m_blank    = 1'b0;
`ifdef SSEG_BLANK_LEADING_ZERO_EN
            m_blank    = (m_idx >= 1) && ((m_disp_bcd >> (4 * m_idx)) == 16'h0);
`endif
            exp_c      = m_blank ? 7'h7F : seg_tab[m_disp_bcd[4*m_idx +: 4]];
            exp_dp     = ~m_disp_dp[m_idx];
            exp_frame  = m_boundary;
            if (m_boundary) begin
                m_disp_bcd = load ? bcd_in : m_sh_bcd;
                m_disp_dp  = load ? dp_in  : m_sh_dp;
            end
            if (load) begin
                m_sh_bcd = bcd_in;
                m_sh_dp  = dp_in;
            end
            m_k++;
        end
    end

    // ------------------------------------------------------- cycle compare
    always @(negedge clk) begin
        if (cmp_en) begin
            n_cmp++;
            if (sseg_a_o !== exp_a || sseg_c_o !== exp_c ||
                dp_o !== exp_dp || frame_o !== exp_frame) begin
                n_fail++;
                $display("FAIL cycle t=%0t: got a=%b c=%b dp=%b fr=%b, expected a=%b c=%b dp=%b fr=%b",
                         $time, sseg_a_o, sseg_c_o, dp_o, frame_o,
                         exp_a, exp_c, exp_dp, exp_frame);
            end
        end
    end

    // ------------------------------------------------------------- helpers
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        load = 1'b1; bcd_in = v; dp_in = d;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Returns on the negedge where frame_o is high, bounded to 64 cycles.
    task automatic wait_frame();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_o !== 1'b1 && n < 64);
        check("frame_seen", {31'b0, frame_o}, 32'd1);
    endtask

    task automatic count_low(input int cycles, output int lows);
        lows = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (sseg_a_o != 4'hF) lows++;
        end
    endtask

    // ------------------------------------------------------------ stimulus
    int frames, lows;
    logic [6:0] lead_seg;

    initial begin
        rst_n = 1'b0; load = 1'b0; bcd_in = '0; dp_in = '0; bright = 4'hF;
`ifdef SSEG_BLANK_LEADING_ZERO_EN
        lead_seg = 7'b1111111;
`else
        lead_seg = 7'b0000001;
`endif

        // Reset defaults and scan order.
        @(negedge clk);
        cmp_en = 1'b1;
        step(2);
        check("rst_anode", {28'b0, sseg_a_o}, 32'hF);
        check("rst_cath",  {25'b0, sseg_c_o}, 32'h7F);
        rst_n = 1'b1;
        frames = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (frame_o) frames++;
            if (i == 1) begin
                check("scan_first_a", {28'b0, sseg_a_o}, 32'hE);
                check("scan_first_c", {25'b0, sseg_c_o}, 32'b0000001);
            end
            if (i == 4)  check("scan_slot0_end", {28'b0, sseg_a_o}, 32'hE);
            if (i == 5)  check("scan_slot1",     {28'b0, sseg_a_o}, 32'hD);
            if (i == 16) check("frame_at_16",    {31'b0, frame_o},  32'd1);
        end
        check("frame_count", frames, 2);

        // Tear-free load of 1234, mid-frame 5678 ignored until next boundary.
        do_load(16'h1234, 4'b0010);
        wait_frame();
        step(1);
        check("l1234_d0", {25'b0, sseg_c_o}, 32'b1001100);
        check("l1234_dp0", {31'b0, dp_o}, 32'd1);
        step(4);
        check("l1234_d1", {25'b0, sseg_c_o}, 32'b0000110);
        check("l1234_dp1", {31'b0, dp_o}, 32'd0);
        check("l1234_a1", {28'b0, sseg_a_o}, 32'hD);
        do_load(16'h5678, 4'b0000);
        step(3);
        check("l1234_d2", {25'b0, sseg_c_o}, 32'b0010010);
        step(4);
        check("l1234_d3", {25'b0, sseg_c_o}, 32'b1001111);
        wait_frame();
        step(1);
        check("l5678_d0", {25'b0, sseg_c_o}, 32'b0000000);
        step(4);
        check("l5678_d1", {25'b0, sseg_c_o}, 32'b0001111);

        // Coincident load: ABCD lands on the boundary edge, beating 9999.
        do_load(16'h9999, 4'b0000);
        step(9);
        do_load(16'hABCD, 4'b0000);
        check("coinc_frame", {31'b0, frame_o}, 32'd1);
        step(1);
        check("abcd_d0", {25'b0, sseg_c_o}, 32'b1000010);
        step(4);
        check("abcd_d1", {25'b0, sseg_c_o}, 32'b0110001);
        step(4);
        check("abcd_d2", {25'b0, sseg_c_o}, 32'b1100000);
        step(4);
        check("abcd_d3", {25'b0, sseg_c_o}, 32'b0001000);

        // PWM duty.
        bright = 4'd4;
        count_low(64, lows);
        check("pwm_4_of_16", lows, 16);
        bright = 4'd0;
        count_low(32, lows);
        check("pwm_dark", lows, 0);
        bright = 4'hF;
        count_low(32, lows);
        check("pwm_full", lows, 32);

        // Decimal point and leading digits.
        do_load(16'h0007, 4'b0010);
        wait_frame();
        step(1);
        check("z7_d0", {25'b0, sseg_c_o}, 32'b0001111);
        check("z7_dp0", {31'b0, dp_o}, 32'd1);
        step(4);
        check("z7_d1", {25'b0, sseg_c_o}, {25'b0, lead_seg});
        check("z7_dp1", {31'b0, dp_o}, 32'd0);
        step(4);
        check("z7_d2", {25'b0, sseg_c_o}, {25'b0, lead_seg});
        check("z7_dp2", {31'b0, dp_o}, 32'd1);
        step(4);
        check("z7_d3", {25'b0, sseg_c_o}, {25'b0, lead_seg});

        // Randomized traffic, including loads on random phases and brightness.
        bright = 4'($urandom_range(0, 15));
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            load   = ($urandom_range(0, 11) == 0);
            bcd_in = 16'($urandom);
            dp_in  = 4'($urandom);
            if ($urandom_range(0, 40) == 0) bright = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0) begin
                // Sparse leading zeros exercise the blanking path.
                bcd_in = bcd_in >> (4 * $urandom_range(1, 3));
            end
        end
        load = 1'b0;

        // Reset mid-frame during digit 2 with a load still pending.
        bright = 4'hF;
        wait_frame();
        step(9);
        do_load(16'h4321, 4'b1111);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_a",  {28'b0, sseg_a_o}, 32'hF);
        check("midrst_c",  {25'b0, sseg_c_o}, 32'h7F);
        check("midrst_dp", {31'b0, dp_o},     32'd1);
        check("midrst_fr", {31'b0, frame_o},  32'd0);
        rst_n = 1'b1;
        step(1);
        check("post_rst_a", {28'b0, sseg_a_o}, 32'hE);
        check("post_rst_c", {25'b0, sseg_c_o}, 32'b0000001);
        wait_frame();
        step(1);
        check("shadow_dropped", {25'b0, sseg_c_o}, 32'b0000001);
        check("shadow_dp_dropped", {31'b0, dp_o}, 32'd1);

        step(2);
        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sseg_scan_driver.md
# sseg_scan_driver

Parametrised multiplexed seven-segment display driver: the next-generation replacement for the fixed four-digit scan driver. It scans `DIGITS` common-anode digits and latches a new display value on a strobe, applying it tear-free only at a frame boundary. It decodes hex nibbles with per-digit decimal points and dims the display by PWM on the anode enables. It sits between the datapath (which supplies packed nibbles) and the board's anode and cathode pins.

## Interface
- `DIGITS`, 4, number of digits scanned; legal range 1–8.
- `PRESCALE`, 100000, `clk` cycles per digit slot; must be ≥ 2.
- `PWM_BITS`, 4, width of the brightness control and PWM counter.

- `clk` in 1: the block's only clock; everything is sampled on its rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `bcd_in` in 4*DIGITS: packed nibbles; nibble k (bits 4k+3:4k) drives digit k, and digit 0 is the rightmost.
- `dp_in` in DIGITS: decimal point request per digit, 1 = lit.
- `load` in 1: single-cycle strobe that captures `bcd_in`/`dp_in` into the shadow register.
- `bright` in PWM_BITS: brightness; 0 = dark, all-ones = fully on.
- `sseg_a_o` out DIGITS: anode enables, active-low.
- `sseg_c_o` out 7: cathodes, active-low; bit 6 = a … bit 0 = g.
- `dp_o` out 1: decimal-point cathode, active-low.
- `frame_o` out 1: one-cycle pulse at each frame boundary.

## Operation
- **Prescaler.** `presc` counts 0..PRESCALE-1 and wraps. `tick` is true when `presc == PRESCALE-1`.
- **Digit index.** `idx` advances on `tick` through 0..DIGITS-1 and wraps to 0.
- **Frame boundary.** A frame boundary is a `tick` with `idx == DIGITS-1`.
- **Double buffer.**
  - `load` = 1 writes `{bcd_in, dp_in}` into the shadow register.
  - On a frame boundary, the shadow register is copied into the display register.
  - If `load` and a frame boundary coincide, the display register takes `bcd_in`/`dp_in` directly, so the newest value wins.
  - A `load` with no frame boundary never alters the digits currently being shown.
- **Decode.** The nibble selects the pattern: 0–9 as standard digits; 10–15 as A, b, C, d, E, F. For example, 0 gives `sseg_c_o` = 7'b0000001 and 8 gives 7'b0000000.
- **Anode.** Only bit `idx` of `sseg_a_o` can be low, gated by PWM.
- **PWM.**
  - `pwm_cnt` (PWM_BITS wide) increments every cycle and wraps.
  - The anode is enabled when `pwm_cnt < bright`.
  - `bright` = all-ones forces the anode on continuously.
  - `bright` = 0 keeps all anodes high (off).
- **dp_o.** Low when the displayed `dp` bit of the current digit is 1.

## Timing
- **Reset values** (after any clock edge with `rst_n` = 0):
  - `presc`, `idx`, `pwm_cnt`, shadow register, display register = 0.
  - `sseg_a_o` = all-ones, `sseg_c_o` = 7'b1111111, `dp_o` = 1, `frame_o` = 0.
- **Reset mid-scan or mid-load.** Reset aborts the scan. The pending shadow value is discarded, and outputs return to reset values on that edge.
- **Registered outputs.** `sseg_a_o`, `sseg_c_o` and `dp_o` are registered with 1-cycle latency. After `idx` becomes k, the outputs show digit k from the following edge.
- **Digit slot length.** Each digit is therefore shown for exactly PRESCALE cycles.
- **frame_o.** High for the one cycle following the frame-boundary edge, aligned with the display register update.
- **Load-to-display latency.** The first displayed cycle of a new value is ≤ DIGITS*PRESCALE + 1 cycles after `load`.
- **Input sampling.** `bright` is sampled every cycle; a change takes effect at the next PWM compare.
- **DIGITS = 1.** Every `tick` is a frame boundary.

## Configuration
- **`SSEG_BLANK_LEADING_ZERO_EN` defined:**
  - Digit k (k ≥ 1) is blanked when its displayed nibble and all higher nibbles are 0.
  - Blanked means `sseg_c_o` = 7'b1111111.
  - Digit 0 is never blanked.
  - `dp_o` still follows `dp` on a blanked digit.
  - The anode still scans normally.
- **Undefined:** every digit, including leading zeros, is decoded normally.

## Test plan
- **Reset defaults.** DIGITS=4, PRESCALE=4: hold `rst_n`=0 for 3 cycles, release → `sseg_a_o`=4'b1111 for one cycle, then 4'b1110 for 4 cycles, then 4'b1101 for 4 cycles…; `frame_o` pulses once every 16 cycles.
- **Tear-free load.** `load` with `bcd_in`=16'h1234 and `bright`=all-ones → digits 0..3 show 4, 3, 2, 1 (`sseg_c_o` 7'b1001100, 0000110, 0010010, 1001111), starting only after the next `frame_o`. A mid-frame `load` of 16'h5678 changes nothing until the following frame boundary.
- **Coincident load.** Assert `load` with 16'hABCD on the frame-boundary cycle → the next frame shows D, C, b, A (`sseg_c_o` 7'b1000010, 0110001, 1100000, 0001000), not the previous shadow value.
- **PWM.** `bright`=4'd4, PWM_BITS=4 → the active anode is low 4 of every 16 cycles. `bright`=0 → `sseg_a_o` stays all-ones. `bright`=4'hF → the active anode is low continuously.
- **Decimal points and blanking.** `dp_in`=4'b0010 → `dp_o`=0 only during digit 1's slot. With `SSEG_BLANK_LEADING_ZERO_EN` and `bcd_in`=16'h0007 → digits 3..1 show `sseg_c_o`=7'b1111111 and digit 0 shows 7. Without the macro → digits 3..1 show 7'b0000001.
- **Reset mid-frame.** Assert `rst_n`=0 in the middle of digit 2's slot → the next edge gives all-ones anodes and cathodes, and the display register is 0.
